multicycle_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 3-bit-opcode datapath. Replaces single-cycle decode:

---
 rtl/multicycle_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the 3-bit-opcode datapath. It runs each
//   instruction through fetch/decode/execute/memory/writeback over several
//   cycles. Instruction fetch and data access share one memory port through
//   a req/ready handshake.
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   opcode[5:0]       IR[31:26], sampled in DECODE
//   mem_ready         memory completes the current access this cycle
//   mem_req, mem_we   memory request (held until ready) and write strobe
//   ir_load, pc_load  IR / PC load strobes; pc_src selects PC+4 or jump target
//   reg_write, reg_dst, mem_to_reg   register file write controls
//   alu_op, alu_src, sign_or_zero    ALU and immediate controls
//   state[3:0]        current state (debug)
//   retire            pulse on the final cycle of each instruction
//   fault             sticky; set on illegal opcode or memory timeout
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_load,
  output logic       pc_load,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       sign_or_zero,
  output logic [3:0] state,
  output logic       retire,
  output logic       fault
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM    = 4'd5,
    S_WB     = 4'd6,
    S_LWB    = 4'd7,
    S_JUMP   = 4'd8,
    S_FAULT  = 4'd9
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_SLI  = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;

  // Last wait cycle allowed before the access is declared dead.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic [7:0] wait_cnt;
  logic       fault_q;
  logic       mem_wait;
  logic       timed_out;

  assign mem_wait  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timed_out = mem_wait && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode[2:0];
      // Every non-wait state clears the counter, so entry to FETCH/MEM sees 0.
      if (mem_wait && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
      else                        wait_cnt <= '0;
      if (state_d == S_FAULT) fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_load      = 1'b0;
    pc_load      = 1'b0;
    pc_src       = 2'b00;
    reg_write    = 1'b0;
    reg_dst      = 2'b00;
    mem_to_reg   = 2'b00;
    alu_op       = 2'b00;
    alu_src      = 1'b0;
    sign_or_zero = 1'b1;
    retire       = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_load = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end

      S_DECODE: begin
        if (opcode[5:3] != 3'b000) begin
          state_d = S_FAULT;
        end else begin
          unique case (opcode[2:0])
            OP_R, OP_SLI, OP_ADDI: state_d = S_EXEC;
            OP_LW, OP_SW:          state_d = S_ADDR;
            OP_J, OP_JAL:          state_d = S_JUMP;
            default:               state_d = S_FAULT;
          endcase
        end
      end

      // WB keeps the EXEC ALU controls so the result stays stable while written.
      S_EXEC, S_WB: begin
        unique case (op_q)
          OP_R: begin
            alu_op  = 2'b00;
            alu_src = 1'b0;
          end
          OP_SLI: begin
            alu_op       = 2'b10;
            alu_src      = 1'b1;
            sign_or_zero = 1'b0;
          end
          default: begin
            alu_op  = 2'b11;
            alu_src = 1'b1;
          end
        endcase
        if (state_q == S_WB) begin
          reg_write = 1'b1;
          reg_dst   = (op_q == OP_R) ? 2'b01 : 2'b00;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end

      S_ADDR: begin
        alu_op  = 2'b11;
        alu_src = 1'b1;
        state_d = S_MEM;
      end

      S_MEM: begin
        alu_op  = 2'b11;
        alu_src = 1'b1;
        mem_req = 1'b1;
        mem_we  = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_LWB;
          end
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end

      S_LWB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b01;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        pc_load = 1'b1;
        pc_src  = 2'b01;
        retire  = 1'b1;
        if (op_q == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        state_d = S_FETCH;
      end

      S_FAULT: state_d = S_FAULT;

      default: state_d = S_IDLE;
    endcase
  end

  assign state = state_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: stimulus pushes per-instruction
// expectations (latency, handshake counts, retire-cycle controls), a monitor
// pops and compares on each retire or fault entry.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, ir_load, pc_load, reg_write, alu_src;
  logic       sign_or_zero, retire, fault;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_op;
  logic [3:0] state;

  multicycle_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .pc_load(pc_load),
    .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_op(alu_op), .alu_src(alu_src),
    .sign_or_zero(sign_or_zero), .state(state), .retire(retire), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    int          lat;
    int          reqs;
    int          wes;
    bit          rw_any;
    logic [12:0] ctl;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [2:0] legal [7] = '{3'b000, 3'b001, 3'b110, 3'b100, 3'b101, 3'b010, 3'b011};
  logic [3:0] trace [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: per-instruction cost and retire-cycle controls.
  function automatic exp_t model(input logic [2:0] op, input int fw, input int mw);
    exp_t e;
    bit rw, pcl, src, soz, we, is_mem;
    logic [1:0] dst, m2r, pcs, aop;
    rw = 0; pcl = 0; src = 0; soz = 1; we = 0;
    dst = 2'b00; m2r = 2'b00; pcs = 2'b00; aop = 2'b00;
    e.is_fault = 0;
    case (op)
      3'b000: begin e.lat = 4 + fw; rw = 1; dst = 2'b01; end
      3'b001: begin e.lat = 4 + fw; rw = 1; aop = 2'b10; src = 1; soz = 0; end
      3'b110: begin e.lat = 4 + fw; rw = 1; aop = 2'b11; src = 1; end
      3'b100: begin e.lat = 5 + fw + mw; rw = 1; m2r = 2'b01; end
      3'b101: begin e.lat = 4 + fw + mw; aop = 2'b11; src = 1; we = 1; end
      3'b010: begin e.lat = 3 + fw; pcl = 1; pcs = 2'b01; end
      default: begin
        e.lat = 3 + fw; pcl = 1; pcs = 2'b01; rw = 1; dst = 2'b10; m2r = 2'b10;
      end
    endcase
    is_mem   = (op == 3'b100) || (op == 3'b101);
    e.reqs   = fw + 1 + (is_mem ? mw + 1 : 0);
    e.wes    = (op == 3'b101) ? mw + 1 : 0;
    e.rw_any = rw;
    e.ctl    = {rw, dst, m2r, pcl, pcs, aop, src, soz, we};
    return e;
  endfunction

  function automatic exp_t fault_exp(input int lat, input int reqs);
    exp_t e;
    e.is_fault = 1; e.lat = lat; e.reqs = reqs; e.wes = 0; e.rw_any = 0; e.ctl = '0;
    return e;
  endfunction

  // Monitor
  logic [3:0] prev_state = '0;
  logic       prev_fault = 1'b0;
  bit         active = 0;
  int         cnt = 0, m_reqs = 0, m_wes = 0;
  bit         m_rw = 0;
  exp_t       me;

  always @(negedge clk) begin
    if (state == 4'd1 && prev_state != 4'd1) begin
      active = 1; cnt = 1; m_reqs = 0; m_wes = 0; m_rw = 0;
    end else if (active) begin
      cnt++;
    end
    if (state == 4'd0) active = 0;
    if (active) begin
      m_reqs += int'(mem_req);
      m_wes  += int'(mem_req && mem_we);
      m_rw   |= reg_write;
    end
    if (retire || (fault && !prev_fault)) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event actual retire=%0b fault=%0b required none", retire, fault);
      end else begin
        me = q.pop_front();
        check("event", {30'd0, fault, retire}, me.is_fault ? 32'd2 : 32'd1);
        check("latency", cnt, me.lat);
        check("req_cycles", m_reqs, me.reqs);
        check("we_cycles", m_wes, me.wes);
        check("rw_any", {31'd0, m_rw}, {31'd0, me.rw_any});
        if (!me.is_fault)
          check("retire_ctl", {19'd0, reg_write, reg_dst, mem_to_reg, pc_load, pc_src,
                alu_op, alu_src, sign_or_zero, mem_we}, {19'd0, me.ctl});
      end
    end
    if (fault) begin
      check("fault_state", state, 4'd9);
      check("fault_idle", {mem_req, mem_we, ir_load, pc_load, pc_src, reg_write, reg_dst,
            mem_to_reg, alu_op, alu_src, sign_or_zero, retire}, 32'h0002);
    end
    prev_state = state;
    prev_fault = fault;
  end

  // Stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("reset_state", state, 4'd0);
    check("reset_outs", {mem_req, fault, retire, reg_write, sign_or_zero}, 5'b00001);
  endtask

  // mem_ready is randomised while no request is pending; the DUT must ignore it.
  task automatic wait_req();
    int t = 0;
    while (mem_req !== 1'b1 && t < 40) begin
      mem_ready = 1'($urandom_range(0, 1));
      step();
      t++;
    end
    mem_ready = 1'b0;
    check("mem_req_seen", {31'd0, mem_req}, 32'd1);
  endtask

  task automatic serve(input int w);
    wait_req();
    repeat (w) step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
  endtask

  task automatic run_instr(input logic [2:0] op, input int fw, input int mw);
    q.push_back(model(op, fw, mw));
    opcode = {3'b000, op};
    serve(fw);
    step();
    if (op == 3'b100 || op == 3'b101) serve(mw);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 20) begin
      step();
      t++;
    end
    check("queue_drain", q.size(), 0);
  endtask

  initial begin
    int fw, mw;
    logic [2:0] op;

    do_reset();

    // Zero-wait R-type state trace from reset release.
    q.push_back(model(3'b000, 0, 0));
    opcode = 6'b000000;
    mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("r_trace", state, trace[k]);
      if (k < 5) step();
    end
    mem_ready = 1'b0;
    drain();
    do_reset();

    // Ready on the last permitted wait cycle must not fault.
    run_instr(3'b110, 14, 0);
    run_instr(3'b100, 0, 14);
    run_instr(3'b100, 2, 3);
    run_instr(3'b101, 1, 2);
    run_instr(3'b011, 0, 0);

    for (int i = 0; i < 60; i++) begin
      op = legal[$urandom_range(0, 6)];
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) fw = $urandom_range(4, 14);
      if ($urandom_range(0, 9) == 0) mw = $urandom_range(4, 14);
      run_instr(op, fw, mw);
    end
    drain();

    // Illegal opcode: upper bits set.
    do_reset();
    q.push_back(fault_exp(3, 1));
    opcode = 6'b001000;
    serve(0);
    repeat (4) begin mem_ready = 1'($urandom_range(0, 1)); step(); end
    check("fault_sticky_a", {31'd0, fault}, 32'd1);

    // Illegal opcode: reserved 111.
    do_reset();
    q.push_back(fault_exp(5, 3));
    opcode = 6'b000111;
    serve(2);
    repeat (4) begin mem_ready = 1'($urandom_range(0, 1)); step(); end
    check("fault_sticky_b", {31'd0, fault}, 32'd1);

    // Fetch timeout: 15 cycles without ready.
    do_reset();
    q.push_back(fault_exp(16, 15));
    opcode = 6'b000000;
    wait_req();
    repeat (20) step();
    check("fault_fetch_to", {31'd0, fault}, 32'd1);

    // Data access timeout in MEM.
    do_reset();
    q.push_back(fault_exp(19, 16));
    opcode = 6'b000100;
    serve(0);
    step();
    wait_req();
    repeat (20) step();
    check("fault_mem_to", {31'd0, fault}, 32'd1);

    // Reset in the middle of a pending data access.
    do_reset();
    opcode = 6'b000100;
    serve(0);
    step();
    wait_req();
    step();
    step();
    check("mem_req_held", {state, mem_req}, {27'd0, 4'd5, 1'b1});
    reset = 1'b1;
    step();
    check("mid_mem_reset", {state, mem_req, fault}, {26'd0, 4'd0, 1'b0, 1'b0});
    reset = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
